// File: rtl/dsa_job_sched.sv
// Round-robin job intake from two requesters into a small FIFO, then one-at-a-time dispatch to the scaling core.
// Push-to-start latency 3 cycles, done-to-report 1 cycle; a requester is held off (ready low) while the FIFO is full.
module dsa_job_sched #(
    parameter int AW         = 12,
    parameter int FIFO_DEPTH = 4,
    parameter int TO_W       = 24
) (
    input  logic                          clk_50,
    input  logic                          rst,
    input  logic                          req0_valid,
    output logic                          req0_ready,
    input  logic [15:0]                   req0_w,
    input  logic [15:0]                   req0_h,
    input  logic [15:0]                   req0_scale,
    input  logic                          req1_valid,
    output logic                          req1_ready,
    input  logic [15:0]                   req1_w,
    input  logic [15:0]                   req1_h,
    input  logic [15:0]                   req1_scale,
    output logic                          core_start,
    input  logic                          core_done,
    output logic [15:0]                   cfg_in_w,
    output logic [15:0]                   cfg_in_h,
    output logic [15:0]                   cfg_scale_q88,
    output logic                          cmp_valid,
    output logic                          cmp_src,
    output logic [1:0]                    cmp_err,
    output logic                          sched_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   jobs_ok
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [31:0] MAX_PIX = 32'(1) << AW;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_START, S_WAIT, S_REPORT} state_t;

    typedef struct packed {
        logic        src;
        logic [15:0] w;
        logic [15:0] h;
        logic [15:0] scale;
    } job_t;

    state_t            state_q, state_d;
    job_t              fifo_mem_q [FIFO_DEPTH];
    job_t              fifo_mem_d [FIFO_DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic              last_grant_q, last_grant_d;
    job_t              job_q, job_d;
    logic              src_q, src_d;
    logic [15:0]       cfg_w_q, cfg_w_d, cfg_h_q, cfg_h_d, cfg_s_q, cfg_s_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic              core_start_q, core_start_d;
    logic              cmp_valid_q, cmp_valid_d;
    logic              cmp_src_q, cmp_src_d;
    logic [1:0]        cmp_err_q, cmp_err_d;
    logic              busy_q, busy_d;
    logic [15:0]       jobs_ok_q, jobs_ok_d;

    logic              full, empty, elig0, elig1, gnt0, gnt1, push, pop, job_valid;
    logic [31:0]       area;
    job_t              push_job;

    assign full  = (level_q == LW'(FIFO_DEPTH));
    assign empty = (level_q == '0);
    assign elig0 = req0_valid & ~full;
    assign elig1 = req1_valid & ~full;
    // On a tie the requester that was not granted last wins.
    assign gnt0  = elig0 & (~elig1 | last_grant_q);
    assign gnt1  = elig1 & (~elig0 | ~last_grant_q);
    assign push  = gnt0 | gnt1;
    assign pop   = (state_q == S_IDLE) & ~empty;
    assign push_job = gnt0 ? job_t'{1'b0, req0_w, req0_h, req0_scale}
                           : job_t'{1'b1, req1_w, req1_h, req1_scale};

    assign area      = 32'(job_q.w) * 32'(job_q.h);
    assign job_valid = (job_q.w >= 16'd2) && (job_q.h >= 16'd2) && (area <= MAX_PIX) &&
                       (job_q.scale != 16'd0) && (job_q.scale <= 16'h0100);

    always_comb begin
        state_d      = state_q;
        fifo_mem_d   = fifo_mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        last_grant_d = last_grant_q;
        job_d        = job_q;
        src_d        = src_q;
        cfg_w_d      = cfg_w_q;
        cfg_h_d      = cfg_h_q;
        cfg_s_d      = cfg_s_q;
        to_cnt_d     = to_cnt_q;
        jobs_ok_d    = jobs_ok_q;
        core_start_d = 1'b0;
        cmp_valid_d  = 1'b0;
        cmp_src_d    = 1'b0;
        cmp_err_d    = 2'b00;

        if (push) begin
            fifo_mem_d[wr_ptr_q] = push_job;
            wr_ptr_d             = wr_ptr_q + 1'b1;
            last_grant_d         = gnt1;
        end
        if (pop) begin
            job_d    = fifo_mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        level_d = level_q + LW'(push) - LW'(pop);

        case (state_q)
            S_IDLE: begin
                if (!empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                cfg_w_d = job_q.w;
                cfg_h_d = job_q.h;
                cfg_s_d = job_q.scale;
                src_d   = job_q.src;
                if (job_valid) begin
                    state_d      = S_START;
                    core_start_d = 1'b1;
                end else begin
                    state_d     = S_REPORT;
                    cmp_valid_d = 1'b1;
                    cmp_src_d   = job_q.src;
                    cmp_err_d   = 2'b01;
                end
            end
            S_START: begin
                to_cnt_d = '0;
                state_d  = S_WAIT;
            end
            S_WAIT: begin
                to_cnt_d = to_cnt_q + 1'b1;
                // Terminal count is judged on the incremented value so the
                // report lands exactly 2^TO_W cycles after the start pulse.
                if (core_done) begin
                    state_d     = S_REPORT;
                    cmp_valid_d = 1'b1;
                    cmp_src_d   = src_q;
                    cmp_err_d   = 2'b00;
                end else if (&to_cnt_d) begin
                    state_d     = S_REPORT;
                    cmp_valid_d = 1'b1;
                    cmp_src_d   = src_q;
                    cmp_err_d   = 2'b10;
                end
            end
            S_REPORT: begin
                if (cmp_err_q == 2'b00) jobs_ok_d = jobs_ok_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_50 or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_mem_q[i] <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            level_q      <= '0;
            last_grant_q <= 1'b1;
            job_q        <= '0;
            src_q        <= 1'b0;
            cfg_w_q      <= '0;
            cfg_h_q      <= '0;
            cfg_s_q      <= '0;
            to_cnt_q     <= '0;
            core_start_q <= 1'b0;
            cmp_valid_q  <= 1'b0;
            cmp_src_q    <= 1'b0;
            cmp_err_q    <= 2'b00;
            busy_q       <= 1'b0;
            jobs_ok_q    <= '0;
        end else begin
            state_q      <= state_d;
            fifo_mem_q   <= fifo_mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            level_q      <= level_d;
            last_grant_q <= last_grant_d;
            job_q        <= job_d;
            src_q        <= src_d;
            cfg_w_q      <= cfg_w_d;
            cfg_h_q      <= cfg_h_d;
            cfg_s_q      <= cfg_s_d;
            to_cnt_q     <= to_cnt_d;
            core_start_q <= core_start_d;
            cmp_valid_q  <= cmp_valid_d;
            cmp_src_q    <= cmp_src_d;
            cmp_err_q    <= cmp_err_d;
            busy_q       <= busy_d;
            jobs_ok_q    <= jobs_ok_d;
        end
    end

    assign req0_ready    = gnt0;
    assign req1_ready    = gnt1;
    assign core_start    = core_start_q;
    assign cfg_in_w      = cfg_w_q;
    assign cfg_in_h      = cfg_h_q;
    assign cfg_scale_q88 = cfg_s_q;
    assign cmp_valid     = cmp_valid_q;
    assign cmp_src       = cmp_src_q;
    assign cmp_err       = cmp_err_q;
    assign sched_busy    = busy_q;
    assign fifo_level    = level_q;
    assign jobs_ok       = jobs_ok_q;

endmodule
